// File: rtl/spi_slave_sync.sv
// SPI target running entirely in the system clock domain; SCLK/CS/MOSI are oversampled through
// 2-FF synchronisers and bytes are exchanged full duplex, MSB first, with valid/ready user handshakes.
module spi_slave_sync #(
  parameter logic       CPOL       = 1'b0,
  parameter logic       CPHA       = 1'b0,
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CSLow,
  input  logic       i_SPI_Mosi,
  output logic       o_SPI_Miso,
  output logic       o_SPI_Miso_En,
  input  logic [7:0] i_Tx_Byte,
  input  logic       i_Tx_Valid,
  output logic       o_Tx_Ready,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  output logic       o_Tx_Underrun,
  output logic       o_Busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_XFER} state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic       r_cs_s1, r_cs_s2;
  logic       r_mosi_s1, r_mosi_s2, r_mosi_d;
  logic       r_lead_p, r_trail_p;

  logic [2:0] r_bit_cnt;
  logic       r_first;
  logic       r_full;
  logic [7:0] r_slot;
  logic [7:0] r_tx_sr;
  logic [6:0] r_rx_sr;
  logic       r_miso;
  logic [7:0] r_rx_byte;
  logic       r_rx_valid;
  logic       r_underrun;

  logic       w_cs_act, w_xfer, w_lead, w_trail, w_sample, w_shift_edge;
  logic       w_load_start, w_load_edge, w_load, w_present, w_shift, w_fill;
  logic [7:0] w_load_byte;

  // Synchroniser stage; CS resets deasserted and SCLK to its idle level so no false edge follows reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_d  <= CPOL;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_mosi_d  <= 1'b0;
      r_lead_p  <= 1'b0;
      r_trail_p <= 1'b0;
    end else begin
      r_sclk_s1 <= i_SPI_Clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= i_SPI_CSLow;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= i_SPI_Mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_d  <= r_mosi_s2;
      r_lead_p  <= (r_sclk_s2 != CPOL) && (r_sclk_d == CPOL);
      r_trail_p <= (r_sclk_s2 == CPOL) && (r_sclk_d != CPOL);
    end
  end

  // Edge stage: registered edge pulses act one cycle after detection, with MOSI delayed to match
  assign w_cs_act     = ~r_cs_s2;
  assign w_xfer       = (r_state == S_XFER) && w_cs_act;
  assign w_lead       = r_lead_p && w_xfer;
  assign w_trail      = r_trail_p && w_xfer;
  assign w_sample     = CPHA ? w_trail : w_lead;
  assign w_shift_edge = CPHA ? w_lead : w_trail;
  assign w_load_start = (r_state == S_LOAD) && w_cs_act;
  assign w_load_edge  = w_shift_edge && (r_bit_cnt == 3'd0) && !(CPHA && r_first);
  assign w_load       = w_load_start || w_load_edge;
  assign w_present    = w_shift_edge && CPHA && r_first;
  assign w_shift      = w_shift_edge && !w_load_edge && !w_present;
  assign w_load_byte  = r_full ? r_slot : DEFAULT_TX;
  assign w_fill       = i_Tx_Valid && !r_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_act) w_next = S_LOAD;
      S_LOAD:  w_next = S_XFER;
      S_XFER:  w_next = S_XFER;
      default: w_next = S_IDLE;
    endcase
    if (!w_cs_act) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full     <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_first    <= 1'b0;
      r_miso     <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= w_load && !r_full;
      // fill only happens with the slot empty, so a same-cycle load never sees the new byte
      if (w_fill)      r_full <= 1'b1;
      else if (w_load) r_full <= 1'b0;
      if (!w_cs_act || w_load_start) r_bit_cnt <= 3'd0;
      else if (w_sample)             r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sample && (r_bit_cnt == 3'd7)) begin
        r_rx_byte  <= {r_rx_sr, r_mosi_d};
        r_rx_valid <= 1'b1;
      end
      if (w_load_start)      r_first <= 1'b1;
      else if (w_shift_edge) r_first <= 1'b0;
      if ((w_load_start && !CPHA) || w_load_edge) r_miso <= w_load_byte[7];
      else if (w_present)                         r_miso <= r_tx_sr[7];
      else if (w_shift)                           r_miso <= r_tx_sr[6];
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) r_slot <= i_Tx_Byte;
    if (w_load)       r_tx_sr <= w_load_byte;
    else if (w_shift) r_tx_sr <= {r_tx_sr[6:0], 1'b0};
    if (w_sample) r_rx_sr <= {r_rx_sr[5:0], r_mosi_d};
  end

  assign o_SPI_Miso    = r_miso;
  assign o_SPI_Miso_En = w_cs_act;
  assign o_Busy        = w_cs_act;
  assign o_Tx_Ready    = ~r_full;
  assign o_Rx_Byte     = r_rx_byte;
  assign o_Rx_Valid    = r_rx_valid;
  assign o_Tx_Underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: one responder per SPI mode, driven by a behavioural SPI master.
`timescale 1ns/1ps
module tb_spi_slave_sync;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] sclk, csn, mosi, tx_valid;
  logic [3:0][7:0] tx_byte;
  logic [3:0] miso, miso_en, tx_ready, rx_valid, underrun, busy;
  logic [3:0][7:0] rx_byte;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_rxq [4][$];
  logic [7:0] exp_mq  [4][$];
  logic [7:0] last_rx [4];
  logic       slot_full [4];
  logic [7:0] slot_val [4];
  int exp_under [4];
  int act_under [4];
  int samp_cyc [4];
  int sess_bytes [4];
  logic [7:0] r, r2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_sync #(.CPOL(g >= 2), .CPHA(g % 2 == 1), .DEFAULT_TX(8'hFF)) u_dut (
      .clk(clk), .reset(reset),
      .i_SPI_Clk(sclk[g]), .i_SPI_CSLow(csn[g]), .i_SPI_Mosi(mosi[g]),
      .o_SPI_Miso(miso[g]), .o_SPI_Miso_En(miso_en[g]),
      .i_Tx_Byte(tx_byte[g]), .i_Tx_Valid(tx_valid[g]), .o_Tx_Ready(tx_ready[g]),
      .o_Rx_Byte(rx_byte[g]), .o_Rx_Valid(rx_valid[g]),
      .o_Tx_Underrun(underrun[g]), .o_Busy(busy[g])
    );
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte start as seen by the user side: pending byte if any, otherwise the default plus an underrun
  task automatic model_load(int m);
    if (slot_full[m]) begin
      exp_mq[m].push_back(slot_val[m]);
      slot_full[m] = 1'b0;
    end else begin
      exp_mq[m].push_back(8'hFF);
      exp_under[m]++;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      exp_rxq[m].delete();
      exp_mq[m].delete();
      last_rx[m]   = 8'h00;
      slot_full[m] = 1'b0;
    end
  endtask

  task automatic check_reset();
    for (int m = 0; m < 4; m++) begin
      check($sformatf("rst_miso[%0d]", m), miso[m], 0);
      check($sformatf("rst_miso_en[%0d]", m), miso_en[m], 0);
      check($sformatf("rst_tx_ready[%0d]", m), tx_ready[m], 1);
      check($sformatf("rst_rx_byte[%0d]", m), rx_byte[m], 0);
      check($sformatf("rst_rx_valid[%0d]", m), rx_valid[m], 0);
      check($sformatf("rst_underrun[%0d]", m), underrun[m], 0);
      check($sformatf("rst_busy[%0d]", m), busy[m], 0);
    end
  endtask

  task automatic push_tx(int m, logic [7:0] b);
    int k = 0;
    while (!tx_ready[m] && k < 50) begin tick(1); k++; end
    if (!tx_ready[m]) begin
      checks++; errors++;
      $display("FAIL tx_ready_wait[%0d]: ready stayed 0, required 1", m);
    end else begin
      slot_full[m] = 1'b1;
      slot_val[m]  = b;
      tx_byte[m]   = b;
      tx_valid[m]  = 1'b1;
      tick(1);
      tx_valid[m]  = 1'b0;
      check($sformatf("ready_fall[%0d]", m), tx_ready[m], 0);
    end
  endtask

  task automatic wait_rx_valid(int m);
    int k = 0;
    while (!rx_valid[m] && k < 400) begin @(negedge clk); k++; end
    if (!rx_valid[m]) begin
      checks++; errors++;
      $display("FAIL rx_valid_wait[%0d]: no pulse within 400 cycles, required one", m);
    end
    tick(1);
  endtask

  task automatic cs_fall(int m);
    csn[m] = 1'b0;
    sess_bytes[m] = 0;
    model_load(m);
    tick(8);
    check($sformatf("busy_on[%0d]", m), busy[m], 1);
    check($sformatf("miso_en_on[%0d]", m), miso_en[m], 1);
  endtask

  task automatic cs_rise(int m);
    tick(HALF);
    csn[m] = 1'b1;
    exp_mq[m].delete();
    tick(8);
    check($sformatf("busy_off[%0d]", m), busy[m], 0);
    check($sformatf("miso_en_off[%0d]", m), miso_en[m], 0);
    check($sformatf("underruns[%0d]", m), act_under[m], exp_under[m]);
  endtask

  // Master side of one byte (or the first nbits of it) in mode m; rx is what the master sampled
  task automatic xbyte(int m, logic [7:0] tx, int nbits, output logic [7:0] rx);
    logic cpol, cpha;
    logic [7:0] req;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rx = 8'h00;
    if (cpha && sess_bytes[m] > 0) model_load(m);
    if (nbits == 8) exp_rxq[m].push_back(tx);
    if (!cpha) mosi[m] = tx[7];
    for (int i = 0; i < nbits; i++) begin
      tick(HALF);
      sclk[m] = ~cpol;
      if (cpha) mosi[m] = tx[7 - i];
      else begin rx = {rx[6:0], miso[m]}; samp_cyc[m] = cyc; end
      tick(HALF);
      sclk[m] = cpol;
      if (cpha) begin rx = {rx[6:0], miso[m]}; samp_cyc[m] = cyc; end
      else if (i < 7) mosi[m] = tx[6 - i];
    end
    sess_bytes[m]++;
    if (nbits == 8) begin
      if (!cpha) model_load(m);
      if (exp_mq[m].size() == 0) begin
        checks++; errors++;
        $display("FAIL mst_rx[%0d]: got %02h, required no byte", m, rx);
      end else begin
        req = exp_mq[m].pop_front();
        check($sformatf("mst_rx[%0d]", m), rx, req);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid[m]) begin
        if (exp_rxq[m].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexp_rx_valid[%0d]: got pulse with %02h, required none", m, rx_byte[m]);
        end else begin
          last_rx[m] = exp_rxq[m].pop_front();
          check($sformatf("rx_byte[%0d]", m), rx_byte[m], last_rx[m]);
          check($sformatf("rx_latency[%0d]", m), cyc - samp_cyc[m], 4);
        end
      end else begin
        check($sformatf("rx_hold[%0d]", m), rx_byte[m], last_rx[m]);
      end
      if (underrun[m]) act_under[m]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    for (int m = 0; m < 4; m++) begin
      sclk[m] = (m >= 2); csn[m] = 1'b1; mosi[m] = 1'b0;
      tx_valid[m] = 1'b0; tx_byte[m] = 8'h00;
      exp_under[m] = 0; act_under[m] = 0; samp_cyc[m] = 0; sess_bytes[m] = 0;
    end
    model_reset();
    tick(2);
    check_reset();
    reset = 1'b0;
    tick(3);

    // Mode 0 basic exchange
    push_tx(0, 8'h3C);
    cs_fall(0);
    xbyte(0, 8'hA5, 8, r);
    cs_rise(0);
    check("t1_mst_rx", r, 8'h3C);
    check("t1_rx_byte", rx_byte[0], 8'hA5);

    // Remaining modes
    for (int m = 1; m < 4; m++) begin
      push_tx(m, 8'hC3);
      cs_fall(m);
      xbyte(m, 8'h5A, 8, r);
      cs_rise(m);
      check($sformatf("t2_mst_rx[%0d]", m), r, 8'hC3);
      check($sformatf("t2_rx_byte[%0d]", m), rx_byte[m], 8'h5A);
    end

    // No pending byte: default goes out once
    cs_fall(1);
    xbyte(1, 8'h00, 8, r);
    cs_rise(1);
    check("t3_mst_rx", r, 8'hFF);
    check("t3_rx_byte", rx_byte[1], 8'h00);
    check("t3_underrun_count", act_under[1], 1);

    // Back-to-back bytes, second tx byte supplied after the first completes
    push_tx(0, 8'hAB);
    cs_fall(0);
    fork
      begin xbyte(0, 8'h12, 8, r); xbyte(0, 8'h34, 8, r2); end
      begin wait_rx_valid(0); push_tx(0, 8'hCD); end
    join
    cs_rise(0);
    check("t4_mst_rx0", r, 8'hAB);
    check("t4_mst_rx1", r2, 8'hCD);
    check("t4_rx_byte", rx_byte[0], 8'h34);

    // Aborted byte, then a full one
    cs_fall(0);
    xbyte(0, 8'hF0, 4, r);
    cs_rise(0);
    check("t5_rx_unchanged", rx_byte[0], 8'h34);
    cs_fall(0);
    xbyte(0, 8'h96, 8, r);
    cs_rise(0);
    check("t5_rx_byte", rx_byte[0], 8'h96);
    check("t5_mst_rx", r, 8'hFF);

    // Reset in the middle of a byte
    push_tx(3, 8'h11);
    push_tx(2, 8'h77);
    cs_fall(2);
    xbyte(2, 8'hE1, 5, r);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset();
    csn[2] = 1'b1; sclk[2] = 1'b1; mosi[2] = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(4);
    push_tx(2, 8'h4B);
    cs_fall(2);
    xbyte(2, 8'hD2, 8, r);
    cs_rise(2);
    check("t6_mst_rx", r, 8'h4B);
    check("t6_rx_byte", rx_byte[2], 8'hD2);

    tick(10);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("rx_outstanding[%0d]", m), exp_rxq[m].size(), 0);
      check($sformatf("final_underruns[%0d]", m), act_under[m], exp_under[m]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
